// File: rtl/mult3_acc_pkg.sv
// Shared types and helpers for the mult3 multiply-accumulate stage.
package mult3_acc_pkg;

  localparam int SAMPLE_W = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult3_accumulator_if.sv
// Sample input and result output bundle of the mult3 accumulator.
interface mult3_accumulator_if #(
  parameter int ACC_WIDTH = 8,
  parameter int BURST     = 4
);
  import mult3_acc_pkg::*;

  localparam int COUNT_W = clog2(BURST + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_product;
  logic                 in_overflow;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [COUNT_W-1:0]   out_count;
  logic                 out_wrap;

  modport master (
    output in_valid, in_product, in_overflow, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_wrap
  );

  modport slave (
    input  in_valid, in_product, in_overflow, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_wrap
  );

endinterface

// File: rtl/acc_sat_add.sv
// Accumulator adder: raw carry out; sum clamps to all-ones on carry when
// MULT3_ACC_SATURATE_EN is defined, otherwise wraps modulo 2^WIDTH.
module acc_sat_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] raw_sum;
  logic             raw_carry;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a_i    (a_i),
    .b_i    (b_i),
    .cin_i  (1'b0),
    .sum_o  (raw_sum),
    .cout_o (raw_carry)
  );

  assign carry_o = raw_carry;

`ifdef MULT3_ACC_SATURATE_EN
  assign sum_o = raw_carry ? {WIDTH{1'b1}} : raw_sum;
`else
  assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/adder.sv
// Plain ripple-carry adder with carry in and carry out.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/mult3_accumulator.sv
// Sums BURST {overflow,product} samples and holds the total until taken.
// Saturating arithmetic when MULT3_ACC_SATURATE_EN is defined, modulo otherwise.
module mult3_accumulator
  import mult3_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 8,
  parameter int BURST     = 4
) (
  input logic               clk,
  input logic               rst_n,
  mult3_accumulator_if.slave bus
);

  localparam int                 COUNT_W = clog2(BURST + 1);
  localparam logic [COUNT_W-1:0] BURST_C = COUNT_W'(BURST);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [COUNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic                 out_wrap_q, out_wrap_d;

  logic [ACC_WIDTH-1:0] sample;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;
  logic [COUNT_W-1:0]   cnt_inc;

  assign sample  = ACC_WIDTH'({bus.in_overflow, bus.in_product});
  assign cnt_inc = cnt_q + COUNT_W'(1);

  acc_sat_add #(.WIDTH(ACC_WIDTH)) u_add (
    .a_i     (acc_q),
    .b_i     (sample),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wrap_d     = wrap_q;
    out_sum_d  = out_sum_q;
    out_cnt_d  = out_cnt_q;
    out_wrap_d = out_wrap_q;
    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d  = add_sum;
          cnt_d  = cnt_inc;
          wrap_d = wrap_q | add_carry;
          if ((cnt_inc == BURST_C) || bus.flush) begin
            state_d    = HOLD;
            out_sum_d  = add_sum;
            out_cnt_d  = cnt_inc;
            out_wrap_d = wrap_q | add_carry;
          end
        end else if (bus.flush && (cnt_q != '0)) begin
          state_d    = HOLD;
          out_sum_d  = acc_q;
          out_cnt_d  = cnt_q;
          out_wrap_d = wrap_q;
        end
      end
      HOLD: begin
        // Partial sum is cleared only once the result has been taken.
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      out_sum_q  <= '0;
      out_cnt_q  <= '0;
      out_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      out_sum_q  <= out_sum_d;
      out_cnt_q  <= out_cnt_d;
      out_wrap_q <= out_wrap_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_cnt_q;
  assign bus.out_wrap  = out_wrap_q;

endmodule

// File: tb/tb_mult3_accumulator.sv
// Scoreboard bench for mult3_accumulator (8-bit and 5-bit accumulator instances).
module tb_mult3_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mult3_accumulator_if #(.ACC_WIDTH(8), .BURST(4)) bus8 ();
  mult3_accumulator_if #(.ACC_WIDTH(5), .BURST(4)) bus5 ();

  mult3_accumulator #(.ACC_WIDTH(8), .BURST(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  mult3_accumulator #(.ACC_WIDTH(5), .BURST(4)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5.slave)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic [2:0] cnt;
    logic       wrap;
  } res_t;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc  = 0;
  int   m_cnt  = 0;
  bit   m_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_add(input int s);
    m_acc = m_acc + s;
    if (m_acc > 255) begin
      m_wrap = 1'b1;
`ifdef MULT3_ACC_SATURATE_EN
      m_acc = 255;
`else
      m_acc = m_acc - 256;
`endif
    end
    m_cnt = m_cnt + 1;
  endfunction

  function automatic void model_close();
    res_t r;
    r.sum  = m_acc[7:0];
    r.cnt  = m_cnt[2:0];
    r.wrap = m_wrap;
    sb_q.push_back(r);
    m_acc  = 0;
    m_cnt  = 0;
    m_wrap = 1'b0;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_out_sum", bus8.out_sum, e.sum);
        check("sb_out_count", bus8.out_count, e.cnt);
        check("sb_out_wrap", bus8.out_wrap, e.wrap);
      end
    end
  end

  // Offer one sample; returns at posedge+2 after it has been accepted.
  task automatic send(input int s, input bit fl);
    bit ok;
    ok = 1'b0;
    bus8.in_valid    = 1'b1;
    bus8.in_product  = s[2:0];
    bus8.in_overflow = s[3];
    bus8.flush       = fl;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus8.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #2;
    end
    bus8.in_valid = 1'b0;
    bus8.flush    = 1'b0;
    if (!ok) begin
      check("send_timeout", 0, 1);
      return;
    end
    model_add(s);
    if (m_cnt == 4 || fl) begin
      model_close();
      check("hold_entry_out_valid", bus8.out_valid, 1);
      check("hold_entry_in_ready", bus8.in_ready, 0);
    end else begin
      check("accum_in_ready", bus8.in_ready, 1);
    end
  endtask

  task automatic wait_accum();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus8.in_ready === 1'b1) ok = 1'b1;
    end
    if (!ok) check("wait_accum_timeout", 0, 1);
  endtask

  task automatic flush_only();
    wait_accum();
    bus8.in_valid = 1'b0;
    bus8.flush    = 1'b1;
    @(posedge clk);
    #2;
    bus8.flush = 1'b0;
    if (m_cnt > 0) begin
      model_close();
      check("flush_out_valid", bus8.out_valid, 1);
    end else begin
      check("flush_idle_out_valid", bus8.out_valid, 0);
      check("flush_idle_in_ready", bus8.in_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus8.in_valid    = 1'b0;
    bus8.in_product  = 3'd0;
    bus8.in_overflow = 1'b0;
    bus8.flush       = 1'b0;
    bus8.out_ready   = 1'b1;
    bus5.in_valid    = 1'b0;
    bus5.in_product  = 3'd0;
    bus5.in_overflow = 1'b0;
    bus5.flush       = 1'b0;
    bus5.out_ready   = 1'b1;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_out_sum", bus8.out_sum, 0);
    check("rst5_out_valid", bus5.out_valid, 0);
    check("rst5_in_ready", bus5.in_ready, 1);

    // Four samples of 6 back-to-back
    repeat (4) send(6, 1'b0);

    // 5-bit accumulator overflow with four samples of 15
    @(posedge clk);
    #2;
    bus5.in_valid    = 1'b1;
    bus5.in_product  = 3'b111;
    bus5.in_overflow = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    bus5.in_valid = 1'b0;
    check("w5_out_valid", bus5.out_valid, 1);
    check("w5_out_count", bus5.out_count, 4);
    check("w5_out_wrap", bus5.out_wrap, 1);
`ifdef MULT3_ACC_SATURATE_EN
    check("w5_out_sum", bus5.out_sum, 31);
`else
    check("w5_out_sum", bus5.out_sum, 28);
`endif

    // Backpressure with a sample waiting
    bus8.out_ready = 1'b0;
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b0);
    bus8.in_valid    = 1'b1;
    bus8.in_product  = 3'd5;
    bus8.in_overflow = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", bus8.out_valid, 1);
      check("bp_in_ready", bus8.in_ready, 0);
      check("bp_out_sum", bus8.out_sum, 10);
      check("bp_out_count", bus8.out_count, 4);
      check("bp_out_wrap", bus8.out_wrap, 0);
    end
    @(posedge clk);
    #2;
    bus8.out_ready = 1'b1;
    send(5, 1'b0);
    flush_only();

    // Flush after 3 and 5, flush while empty, flush together with an accept
    send(3, 1'b0);
    send(5, 1'b0);
    flush_only();
    flush_only();
    send(2, 1'b0);
    send(7, 1'b1);

    // Reset in the middle of a burst
    send(9, 1'b0);
    send(9, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus8.out_valid, 0);
    check("async_rst_in_ready", bus8.in_ready, 1);
    check("async_rst_out_sum", bus8.out_sum, 0);
    check("async_rst_out_count", bus8.out_count, 0);
    #1;
    rst_n  = 1'b1;
    m_acc  = 0;
    m_cnt  = 0;
    m_wrap = 1'b0;
    repeat (4) send(1, 1'b0);

    repeat (4) @(posedge clk);
    #2;
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
